// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding RV32 load/store unit with read-modify-write sub-word stores
module mem_access_unit #(
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter int unsigned MEM_SIZE = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_wdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [32:0] WIN_LO = {1'b0, MEM_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, MEM_BASE} + 33'(MEM_SIZE) - 33'd1;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  logic        accept;
  logic        req_err;
  logic [32:0] last_addr;
  logic [1:0]  size_m1;
  logic        misaligned;
  logic        bad_funct3;
  logic        out_of_window;
  logic [31:0] word_word_aligned;
  logic [31:0] lane_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [31:0] st_merged;

  assign accept = req_valid & req_ready;
  assign word_word_aligned = {addr_q[31:2], 2'b00};

  // Classify the incoming request: alignment, encoding and address-window legality
  always_comb begin
    size_m1 = 2'd3;
    case (req_funct3[1:0])
      2'b00:   size_m1 = 2'd0;
      2'b01:   size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    if (req_we) begin
      bad_funct3 = (req_funct3 >= 3'd3);
    end else begin
      bad_funct3 = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end
    // 33-bit sum so an access near 0xFFFFFFFF cannot wrap back into the window
    last_addr     = {1'b0, req_addr} + {31'b0, size_m1};
    out_of_window = ({1'b0, req_addr} < WIN_LO) || (last_addr > WIN_HI);
    req_err       = misaligned || bad_funct3 || out_of_window;
  end

  // Sign/zero-extend the addressed lane of the word captured in READ
  always_comb begin
    lane_shifted = word_q >> {addr_q[1:0], 3'b000};
    ld_byte      = lane_shifted[7:0];
    ld_half      = addr_q[1] ? word_q[31:16] : word_q[15:0];
    case (funct3_q)
      3'd0:    ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_value = {24'b0, ld_byte};
      3'd1:    ld_value = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_value = {16'b0, ld_half};
      default: ld_value = word_q;
    endcase
  end

  // Merge store data into the captured word; full-word stores bypass the merge
  always_comb begin
    st_merged = word_q;
    case (funct3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    st_merged[7:0]   = wdata_q[7:0];
          2'd1:    st_merged[15:8]  = wdata_q[7:0];
          2'd2:    st_merged[23:16] = wdata_q[7:0];
          default: st_merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) st_merged[31:16] = wdata_q[15:0];
        else           st_merged[15:0]  = wdata_q[15:0];
      end
      default: st_merged = wdata_q;
    endcase
  end

  // Next-state and request latching
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          we_d     = req_we;
          err_d    = req_err;
          word_d   = 32'b0;
          if (req_err)                          state_d = RESP;
          else if (req_we && req_funct3 == 3'd2) state_d = WRITE;
          else                                   state_d = READ;
        end
      end
      READ: begin
        word_d  = mem_rdata;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state; reset also masks handshakes and the write strobe
  always_comb begin
    req_ready      = (state_q == IDLE) && !rst;
    mem_addr       = (state_q == IDLE) ? 32'b0 : word_word_aligned;
    mem_write_addr = mem_addr;
    mem_we         = (state_q == WRITE) && !rst;
    mem_wdata      = (state_q == WRITE) ? st_merged : 32'b0;
    resp_valid     = (state_q == RESP) && !rst;
    resp_err       = resp_valid && err_q;
    resp_rdata     = (resp_valid && !err_q && !we_q) ? ld_value : 32'b0;
  end

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= 32'b0;
      wdata_q  <= 32'b0;
      word_q   <= 32'b0;
      funct3_q <= 3'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table-driven scoreboard bench for mem_access_unit
module tb_mem_access_unit;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned SIZE = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_wdata;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BASE(BASE), .MEM_SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_write_addr(mem_write_addr), .mem_wdata(mem_wdata)
  );

  logic [31:0] mem [0:4095];
  int          cyc = 0;
  int          wr_count = 0;
  logic [31:0] last_wa, last_wd;
  int          n_total = 0;
  int          n_pass = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    int          n_wr;
    logic [31:0] exp_wa;
    logic [31:0] exp_wd;
  } vec_t;

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE) && (a - BASE < SIZE);
  endfunction

  always_comb begin
    mem_rdata = 32'b0;
    if (in_win(mem_addr)) mem_rdata = mem[(mem_addr - BASE) >> 2];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      wr_count <= wr_count + 1;
      last_wa  <= mem_write_addr;
      last_wd  <= mem_wdata;
      if (in_win(mem_write_addr)) mem[(mem_write_addr - BASE) >> 2] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Response scoreboard and idle-output checks
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        chk("resp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
      end
    end else begin
      chk("idle_resp_zero", {resp_rdata[31:1], resp_rdata[0] | resp_err}, 32'b0);
    end
    if (!mem_we) chk("idle_wdata_zero", mem_wdata, 32'b0);
  end

  task automatic do_req(input vec_t v);
    int   n;
    logic got;
    int   wr0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'b0, req_ready}, 32'd1);
    wr0 = wr_count;
    exp_q.push_back('{v.exp_rdata, v.exp_err, cyc, v.lat});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    chk("resp_seen", {31'b0, got}, 32'd1);
    if (!got) exp_q.delete();
    @(negedge clk);
    chk("ready_after_resp", {31'b0, req_ready}, 32'd1);
    chk("write_count", 32'(wr_count - wr0), 32'(v.n_wr));
    if (v.n_wr != 0) begin
      chk("write_addr", last_wa, v.exp_wa);
      chk("write_data", last_wd, v.exp_wd);
    end
  endtask

  vec_t vecs[18];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'b0;
    mem[32'h100 >> 2] = 32'h8899AABB;
    mem[4095]         = 32'hC300_0000;

    //          we    f3    addr          wdata         rdata         err   lat wr wa            wd
    vecs[0]  = '{1'b0, 3'd0, 32'h80000101, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 3'd5, 32'h80000102, 32'h0,        32'h00008899, 1'b0, 2, 0, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 3'd2, 32'h80000100, 32'h0,        32'h8899AABB, 1'b0, 2, 0, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 3'd1, 32'h80000100, 32'h0,        32'hFFFFAABB, 1'b0, 2, 0, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 3'd4, 32'h80000103, 32'h0,        32'h00000088, 1'b0, 2, 0, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 3'd1, 32'h80000102, 32'h0,        32'hFFFF8899, 1'b0, 2, 0, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 3'd0, 32'h80000102, 32'hFFFFFF11, 32'h0,        1'b0, 3, 1, 32'h80000100, 32'h8811AABB};
    vecs[7]  = '{1'b0, 3'd2, 32'h80000100, 32'h0,        32'h8811AABB, 1'b0, 2, 0, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 3'd1, 32'h80000102, 32'hFFFF1234, 32'h0,        1'b0, 3, 1, 32'h80000100, 32'h1234AABB};
    vecs[9]  = '{1'b1, 3'd2, 32'h80001000, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'h80001000, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 3'd2, 32'h80000102, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 3'd1, 32'h80000001, 32'h1234,     32'h0,        1'b1, 1, 0, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 3'd0, 32'h7FFFFFFF, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0,        32'h0};
    vecs[13] = '{1'b0, 3'd3, 32'h80000100, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0,        32'h0};
    vecs[14] = '{1'b1, 3'd3, 32'h80000100, 32'h5,        32'h0,        1'b1, 1, 0, 32'h0,        32'h0};
    vecs[15] = '{1'b1, 3'd2, 32'h80004000, 32'h5,        32'h0,        1'b1, 1, 0, 32'h0,        32'h0};
    vecs[16] = '{1'b0, 3'd0, 32'h80003FFF, 32'h0,        32'hFFFFFFC3, 1'b0, 2, 0, 32'h0,        32'h0};
    vecs[17] = '{1'b0, 3'd2, 32'h80003FFC, 32'h0,        32'hC3000000, 1'b0, 2, 0, 32'h0,        32'h0};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
    chk("idle_mem_addr", mem_addr, 32'd0);

    for (int i = 0; i < 18; i++) do_req(vecs[i]);

    // Reset while a sub-word store sits in READ: the write and response must never appear
    begin
      int wr0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd0;
      req_addr   = 32'h80000100;
      req_wdata  = 32'h55;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wr0 = wr_count;
      @(negedge clk);
      chk("abort_in_read_addr", mem_addr, 32'h80000100);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("abort_ready_low", {31'b0, req_ready}, 32'd0);
        chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready_back", {31'b0, req_ready}, 32'd1);
      chk("abort_no_write", 32'(wr_count - wr0), 32'd0);
    end
    do_req('{1'b0, 3'd2, 32'h80000100, 32'h0, 32'h1234AABB, 1'b0, 2, 0, 32'h0, 32'h0});

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("tohost_b0", {24'b0, mem[32'h1000 >> 2][7:0]},   32'hEF);
    chk("tohost_b1", {24'b0, mem[32'h1000 >> 2][15:8]},  32'hBE);
    chk("tohost_b2", {24'b0, mem[32'h1000 >> 2][23:16]}, 32'hAD);
    chk("tohost_b3", {24'b0, mem[32'h1000 >> 2][31:24]}, 32'hDE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
